// File: rtl/alu_result_skid.sv
// Two-entry skid buffer between the ALU and writeback, with add/sub flag masking
// and overflow statistics. Entry on edge N is visible at out_* in cycle N+1; in_ready is registered.
module alu_result_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic              in_cout,
  input  logic              in_overflow,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [2:0]        out_flags,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  input  logic              clr_sticky,
  output logic              sticky_ovf,
  output logic [CNT_W-1:0]  ovf_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t              state;
  logic [DATA_W-1:0]   skid_result;
  logic [2:0]          skid_flags;
  logic [CTRL_W-1:0]   skid_ctrl;
  logic [RD_W-1:0]     skid_rd;

  logic       accept;
  logic       pop;
  logic       is_addsub;
  logic       ovf_m;
  logic [2:0] in_flags;

  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign is_addsub = (in_ctrl == CTRL_W'(4'b0010)) || (in_ctrl == CTRL_W'(4'b0110));
  assign ovf_m     = in_overflow & is_addsub;
  assign in_flags  = {ovf_m, in_cout & is_addsub, in_zero};

  // in_ready tracks "next state != TWO", so it only changes on ONE<->TWO moves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_flags   <= '0;
      out_ctrl    <= '0;
      out_rd      <= '0;
      skid_result <= '0;
      skid_flags  <= '0;
      skid_ctrl   <= '0;
      skid_rd     <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_result <= in_result;
            out_flags  <= in_flags;
            out_ctrl   <= in_ctrl;
            out_rd     <= in_rd;
            out_valid  <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            skid_result <= in_result;
            skid_flags  <= in_flags;
            skid_ctrl   <= in_ctrl;
            skid_rd     <= in_rd;
            in_ready    <= 1'b0;
            state       <= TWO;
          end else if (accept && pop) begin
            out_result <= in_result;
            out_flags  <= in_flags;
            out_ctrl   <= in_ctrl;
            out_rd     <= in_rd;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            out_result <= skid_result;
            out_flags  <= skid_flags;
            out_ctrl   <= skid_ctrl;
            out_rd     <= skid_rd;
            in_ready   <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // A set from an accepted overflow takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
      ovf_count  <= '0;
    end else if (accept && ovf_m) begin
      sticky_ovf <= 1'b1;
      if (ovf_count != {CNT_W{1'b1}})
        ovf_count <= ovf_count + CNT_W'(1);
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_skid.sv
// Randomised and directed bench for alu_result_skid against a queue-based reference model.
module tb_alu_result_skid;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic        in_zero, in_cout, in_overflow;
  logic [3:0]  in_ctrl;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic [3:0]  out_ctrl;
  logic [4:0]  out_rd;
  logic        clr_sticky, sticky_ovf;
  logic [CNT_W-1:0] ovf_count;

  alu_result_skid #(.DATA_W(32), .CTRL_W(4), .RD_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_cout(in_cout), .in_overflow(in_overflow),
    .in_ctrl(in_ctrl), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_ctrl(out_ctrl), .out_rd(out_rd),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .ovf_count(ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [2:0]  flags;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
  } entry_t;

  entry_t q[$];
  int     m_count;
  bit     m_sticky;
  int     n_checks, n_errors;
  int     n_accepts;
  bit     ready_dropped;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: model decides from pre-edge inputs, then DUT outputs are compared after the edge.
  task automatic tick();
    bit     acc, pp, addsub;
    entry_t e;
    acc    = in_valid && (q.size() < 2) && rst_n;
    pp     = out_ready && (q.size() > 0) && rst_n;
    addsub = (in_ctrl == 4'd2) || (in_ctrl == 4'd6);
    e.result = in_result;
    e.flags  = {in_overflow & addsub, in_cout & addsub, in_zero};
    e.ctrl   = in_ctrl;
    e.rd     = in_rd;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      m_count  = 0;
      m_sticky = 0;
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_flags", {29'd0, out_flags}, 32'd0);
      chk("rst_out_ctrl", {28'd0, out_ctrl}, 32'd0);
      chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        n_accepts++;
      end
      if (acc && e.flags[2]) begin
        m_sticky = 1;
        if (m_count < CMAX) m_count++;
      end else if (clr_sticky) begin
        m_sticky = 0;
      end
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("sticky_ovf", {31'd0, sticky_ovf}, {31'd0, m_sticky});
    chk("ovf_count", {28'd0, ovf_count}, m_count);
    if (q.size() > 0 && out_valid) begin
      chk("out_result", out_result, q[0].result);
      chk("out_flags", {29'd0, out_flags}, {29'd0, q[0].flags});
      chk("out_ctrl", {28'd0, out_ctrl}, {28'd0, q[0].ctrl});
      chk("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
    end
  endtask

  task automatic drive_rand(input bit v);
    logic [3:0] c;
    case ($urandom_range(0, 3))
      0: c = 4'd2;
      1: c = 4'd6;
      2: c = 4'd0;
      default: c = 4'($urandom);
    endcase
    in_valid    = v;
    in_result   = $urandom;
    in_zero     = 1'($urandom);
    in_cout     = 1'($urandom);
    in_overflow = 1'($urandom);
    in_ctrl     = c;
    in_rd       = 5'($urandom);
  endtask

  task automatic drive_ovf(input logic [3:0] c, input logic [31:0] r);
    in_valid = 1; in_result = r; in_zero = (r == 0); in_cout = 1'b0;
    in_overflow = 1'b1; in_ctrl = c; in_rd = 5'd3;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; m_count = 0; m_sticky = 0; n_accepts = 0;
    rst_n = 0; in_valid = 0; out_ready = 0; clr_sticky = 0;
    in_result = 0; in_zero = 0; in_cout = 0; in_overflow = 0; in_ctrl = 0; in_rd = 0;

    // Reset held for two cycles
    tick(); tick();
    rst_n = 1;

    // Streaming: 8 back-to-back accepts with writeback always ready
    out_ready = 1;
    ready_dropped = 0;
    for (int i = 0; i < 8; i++) begin
      drive_rand(1);
      tick();
      if (!in_ready) ready_dropped = 1;
    end
    chk("stream_ready_held", {31'd0, ready_dropped}, 32'd0);
    in_valid = 0; tick();

    // Stall: A, B land, C is refused while full
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1);
      in_result = 32'hA0 + i;
      tick();
    end
    chk("stall_head_A", out_result, 32'hA0);
    in_valid = 0;
    out_ready = 1;
    tick();
    chk("stall_head_B", out_result, 32'hA1);
    tick();
    chk("stall_drained", {31'd0, out_valid}, 32'd0);

    // Overflow masking
    n_accepts = 0;
    drive_ovf(4'b0010, 32'h8000_0000);
    tick();
    chk("add_ovf_flag", {31'd0, out_flags[2]}, 32'd1);
    drive_ovf(4'b0000, 32'h1234);
    tick();
    chk("and_ovf_masked", {31'd0, out_flags[2]}, 32'd0);
    in_valid = 0; tick();

    // Sticky race: set wins over a same-cycle clear, then a lone clear
    drive_ovf(4'b0110, 32'h7FFF_FFFF);
    clr_sticky = 1;
    tick();
    chk("race_sticky_set", {31'd0, sticky_ovf}, 32'd1);
    in_valid = 0;
    tick();
    chk("race_sticky_clr", {31'd0, sticky_ovf}, 32'd0);
    clr_sticky = 0;

    // Saturation: 17 accepted overflows
    for (int i = 0; i < 17; i++) begin
      drive_ovf(4'b0010, 32'h8000_0000 + i);
      tick();
    end
    chk("ovf_saturated", {28'd0, ovf_count}, CMAX);
    in_valid = 0; tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive_rand(($urandom_range(0, 3) != 0));
      out_ready  = ($urandom_range(0, 2) != 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      tick();
    end
    clr_sticky = 0;

    // Reset while holding two entries
    out_ready = 0;
    while (in_ready) begin
      drive_rand(1);
      tick();
    end
    in_valid = 0;
    rst_n = 0;
    tick();
    chk("rst_in_two_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1;
    out_ready = 1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
